bennett_clock_gen: RTL

Parametrised multi-phase Bennett clock generator for the adiabatic datapath. Produces a thermometer-coded ramp of PHASES complementary clock rails (clkp/clkn) that charge up level by level, dwell at full, then discharge in reverse order. Master clock (mclk) and end-of-cycle flag (inst_flag) drive the instruction sequencer. Over the fixed 11-rail generator it adds programmable step duration, programmable top dwell, single-shot mode, a busy status and a level readout.

---
 rtl/bennett_pkg.sv | 28 ++
 rtl/bennett_step_timer.sv | 33 +++
 rtl/bennett_clock_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bennett_pkg.sv
// Shared types and helpers for the multi-phase Bennett clock generator.
// State encodings are plain constants so legacy netlists can probe them.
package bennett_pkg;

   localparam int MAX_PHASES = 64;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_UP   = 3'd1;
   localparam state_t ST_HOLD = 3'd2;
   localparam state_t ST_DOWN = 3'd3;
   localparam state_t ST_DONE = 3'd4;

   function automatic int level_width(input int phases);
      return $clog2(phases + 1);
   endfunction

   // Rail i is asserted iff i < lvl; callers truncate to their rail count.
   function automatic logic [MAX_PHASES-1:0] therm(input int lvl);
      logic [MAX_PHASES-1:0] t;
      for (int i = 0; i < MAX_PHASES; i++) begin
         t[i] = (i < lvl);
      end
      return t;
   endfunction

endpackage

// File: rtl/bennett_step_timer.sv
// Loadable down-counter pacing ramp levels; expire is high while the count is zero.
module bennett_step_timer
   import bennett_pkg::*;
#(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          expire
);

   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - ONE;
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/bennett_clock_gen.sv
// Multi-phase Bennett clock generator: thermometer ramp up, dwell at full, ramp down,
// with registered complementary rails, master clock and end-of-cycle flag.
module bennett_clock_gen
   import bennett_pkg::*;
#(
   parameter  int PHASES = 11,
   parameter  int DIV_W  = 4,
   parameter  int HOLD_W = 4,
   localparam int LW     = level_width(PHASES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              single,
   input  logic              start,
   input  logic [DIV_W-1:0]  step_div,
   input  logic [HOLD_W-1:0] hold_cycles,
   output logic [PHASES-1:0] clkp,
   output logic [PHASES-1:0] clkn,
   output logic              mclk,
   output logic              inst_flag,
   output logic              busy,
   output logic [LW-1:0]     level
);

   // Wide enough for D + H - 1 at maximum inputs without wrapping.
   localparam int CW = ((DIV_W > HOLD_W) ? DIV_W : HOLD_W) + 1;

   localparam logic [LW-1:0] FULL    = LW'(PHASES);
   localparam logic [LW-1:0] L_ONE   = LW'(1);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   state_t              state;
   state_t              state_n;
   logic [LW-1:0]       level_n;
   logic [DIV_W-1:0]    div_sh;
   logic [HOLD_W-1:0]   hold_sh;
   logic [DIV_W-1:0]    div_eff;
   logic                launch;
   logic                expire;
   logic                t_load;
   logic                t_clear;
   logic [CW-1:0]       t_val;
   logic [PHASES-1:0]   rails_n;

   assign div_eff = (step_div == '0) ? DIV_W'(1) : step_div;
   assign launch  = single ? start : en;

   bennett_step_timer #(
      .CW(CW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (t_clear),
      .load     (t_load),
      .load_val (t_val),
      .expire   (expire)
   );

   // Next-state and timer control; shadows supply D and H once a ramp is running.
   always_comb begin
      state_n = state;
      level_n = level;
      t_load  = 1'b0;
      t_clear = 1'b0;
      t_val   = '0;
      case (state)
         ST_IDLE: begin
            if (launch) begin
               state_n = ST_UP;
               level_n = L_ONE;
               t_load  = 1'b1;
               t_val   = CW'(div_eff) - C_ONE;
            end else begin
               t_clear = 1'b1;
            end
         end
         ST_UP: begin
            if (expire) begin
               level_n = level + L_ONE;
               t_load  = 1'b1;
               if (level == FULL - L_ONE) begin
                  state_n = ST_HOLD;
                  t_val   = CW'(div_sh) + CW'(hold_sh) - C_ONE;
               end else begin
                  t_val   = CW'(div_sh) - C_ONE;
               end
            end
         end
         ST_HOLD: begin
            if (expire) begin
               state_n = ST_DOWN;
               level_n = FULL - L_ONE;
               t_load  = 1'b1;
               t_val   = CW'(div_sh) - C_ONE;
            end
         end
         ST_DOWN: begin
            if (expire) begin
               level_n = level - L_ONE;
               if (level == L_ONE) begin
                  state_n = ST_DONE;
               end else begin
                  t_load  = 1'b1;
                  t_val   = CW'(div_sh) - C_ONE;
               end
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            level_n = '0;
         end
      endcase
      rails_n = PHASES'(therm(int'(level_n)));
   end

   // All outputs come straight from flops so the rails cannot glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         level     <= '0;
         clkp      <= '0;
         clkn      <= '1;
         mclk      <= 1'b0;
         inst_flag <= 1'b0;
         busy      <= 1'b0;
         div_sh    <= '0;
         hold_sh   <= '0;
      end else begin
         state     <= state_n;
         level     <= level_n;
         clkp      <= rails_n;
         clkn      <= ~rails_n;
         mclk      <= (state_n == ST_HOLD) || (state_n == ST_DOWN) || (state_n == ST_DONE);
         inst_flag <= (state_n == ST_DONE);
         busy      <= (state_n != ST_IDLE);
         if ((state == ST_IDLE) && launch) begin
            div_sh  <= div_eff;
            hold_sh <= hold_cycles;
         end
      end
   end

endmodule
